// File: rtl/sram_ctrl_pkg.sv
// Shared constants and enumerations for the instruction-SRAM front-end.
// AW/DW/DEPTH describe the 32 x 72 single-port array behind the controller.
package sram_ctrl_pkg;

  localparam int AW    = 5;
  localparam int DW    = 72;
  localparam int DEPTH = 32;

  // Grant vector bit positions produced by rr_arb2.
  localparam int GNT_RD_BIT = 0;
  localparam int GNT_WR_BIT = 1;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_e;

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response and SRAM-port signals of sram_ctrl, bundled as one interface.
// slave = the controller's view, master = the requesters plus the SRAM macro.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic          init_req;
  logic          busy;

  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          mem_ena;
  logic          mem_wea;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  init_req,
    input  rd_valid, rd_addr,
    input  wr_valid, wr_addr, wr_data,
    input  mem_dout,
    output busy,
    output rd_ready, rd_data_valid, rd_data,
    output wr_ready,
    output mem_ena, mem_wea, mem_addr, mem_din
  );

  modport master (
    output init_req,
    output rd_valid, rd_addr,
    output wr_valid, wr_addr, wr_data,
    output mem_dout,
    input  busy,
    input  rd_ready, rd_data_valid, rd_data,
    input  wr_ready,
    input  mem_ena, mem_wea, mem_addr, mem_din
  );

endinterface

// File: rtl/sram_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter: under contention the side that did not
// win last time is granted. Purely combinational; history lives in the caller.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic       i_req_rd,
  input  logic       i_req_wr,
  input  grant_e     i_last_grant,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req_rd && i_req_wr) begin
      if (i_last_grant == GNT_WR) begin
        o_gnt[GNT_RD_BIT] = 1'b1;
      end else begin
        o_gnt[GNT_WR_BIT] = 1'b1;
      end
    end else if (i_req_rd) begin
      o_gnt[GNT_RD_BIT] = 1'b1;
    end else if (i_req_wr) begin
      o_gnt[GNT_WR_BIT] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Arbitrates fetch reads and refill writes onto one SRAM port, zero-fills the
// array after reset or on init_req, and registers read data one cycle later.
module sram_ctrl
  import sram_ctrl_pkg::*;
(
  input  logic        clka,
  input  logic        rst,
  sram_ctrl_if.slave  bus
);

  state_e        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;
  logic          r_rd_dv;
  logic [DW-1:0] r_rd_data;
  grant_e        r_last_grant;

  logic [1:0]    w_gnt;
  logic          w_serve;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic          w_mem_ena;
  logic          w_mem_wea;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_din;

  rr_arb2 u_arb (
    .i_req_rd     (bus.rd_valid),
    .i_req_wr     (bus.wr_valid),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  // An init_req in the serving state pre-empts that cycle's requests.
  assign w_serve      = (r_state == ST_SERVE) && !bus.init_req;
  assign bus.rd_ready = w_serve && w_gnt[GNT_RD_BIT];
  assign bus.wr_ready = w_serve && w_gnt[GNT_WR_BIT];
  assign w_rd_acc     = bus.rd_valid && bus.rd_ready;
  assign w_wr_acc     = bus.wr_valid && bus.wr_ready;

  always_comb begin
    w_mem_ena  = 1'b0;
    w_mem_wea  = 1'b0;
    w_mem_addr = r_cnt;
    w_mem_din  = '0;
    if (r_state == ST_SWEEP) begin
      w_mem_ena  = 1'b1;
      w_mem_wea  = 1'b1;
      w_mem_addr = r_cnt;
    end else if (w_rd_acc) begin
      w_mem_ena  = 1'b1;
      w_mem_addr = bus.rd_addr;
    end else if (w_wr_acc) begin
      w_mem_ena  = 1'b1;
      w_mem_wea  = 1'b1;
      w_mem_addr = bus.wr_addr;
      w_mem_din  = bus.wr_data;
    end
  end

  // The sweep state would otherwise enable writes while reset is still held.
  assign bus.mem_ena  = w_mem_ena && !rst;
  assign bus.mem_wea  = w_mem_wea && !rst;
  assign bus.mem_addr = w_mem_addr;
  assign bus.mem_din  = w_mem_din;

  assign bus.busy          = r_busy;
  assign bus.rd_data_valid = r_rd_dv;
  assign bus.rd_data       = r_rd_data;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_state      <= ST_SWEEP;
      r_cnt        <= '0;
      r_busy       <= 1'b1;
      r_rd_dv      <= 1'b0;
      r_rd_data    <= '0;
      r_last_grant <= GNT_WR;
    end else begin
      // A read accepted just before a sweep starts still completes here.
      r_rd_dv <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= bus.mem_dout;
      end

      if (w_rd_acc) begin
        r_last_grant <= GNT_RD;
      end else if (w_wr_acc) begin
        r_last_grant <= GNT_WR;
      end

      case (r_state)
        ST_SWEEP: begin
          if (bus.init_req) begin
            r_cnt <= '0;
          end else if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= ST_SERVE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        ST_SERVE: begin
          if (bus.init_req) begin
            r_state <= ST_SWEEP;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_SWEEP;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Sequencing and arbitration front-end for the 32-entry × 72-bit single-port instruction SRAM in the fetch path. Shares the one SRAM port between a fetch read requester and a refill write requester with 2-way round-robin arbitration. Runs a zero-fill sweep of all entries after reset or on command. Registers the SRAM's combinational read data into a one-cycle-latency response.

## Interface
- AW, 5, SRAM address width
- DW, 72, SRAM data width (8×9 bits)
- DEPTH, 32, entries swept by init; equals 2**AW
- clka  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- init_req  in  1  pulse; start a zero-fill sweep
- busy  out  1  high while sweeping; no requests accepted
- rd_valid  in  1  fetch read request
- rd_ready  out  1  read request accepted when rd_valid && rd_ready
- rd_addr  in  AW  read address
- rd_data_valid  out  1  read response strobe, one cycle
- rd_data  out  DW  read response data
- wr_valid  in  1  refill write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- mem_ena  out  1  SRAM enable
- mem_wea  out  1  SRAM write enable
- mem_addr  out  AW  SRAM address
- mem_din  out  DW  SRAM write data
- mem_dout  in  DW  SRAM read data, combinational from mem_addr

## Operation
- States: ST_SWEEP, ST_SERVE.
- Reset values: state = ST_SWEEP, sweep counter = 0, busy = 1, rd_data_valid = 0, rd_data = 0, last_grant = WR.
- While rst is high, mem_ena and mem_wea are forced to 0.
- ST_SWEEP:
  - Drive mem_ena = mem_wea = 1, mem_addr = counter, mem_din = 0, rd_ready = wr_ready = 0.
  - Counter increments each cycle. After the write at DEPTH-1, go to ST_SERVE and clear busy.
  - init_req during a sweep restarts the counter at 0.
- ST_SERVE, arbitration (combinational, from the rr_arb2 sub-module):
  - Only rd_valid: rd_ready = 1.
  - Only wr_valid: wr_ready = 1.
  - Both: grant the side opposite last_grant.
  - At most one of rd_ready/wr_ready is high in any cycle.
  - last_grant updates only on an accepted request.
- Accepted read: mem_ena = 1, mem_wea = 0, mem_addr = rd_addr. Next edge captures mem_dout into rd_data and pulses rd_data_valid. Responses have no backpressure.
- Accepted write: mem_ena = mem_wea = 1, mem_addr = wr_addr, mem_din = wr_data.
- No accepted request: mem_ena = 0.
- init_req in ST_SERVE: that cycle's requests are not accepted (ready = 0). Next state is ST_SWEEP with counter 0 and busy = 1.
- A read accepted in the cycle before the sweep starts still returns its rd_data_valid.
- rd_data holds its last value when rd_data_valid is 0.

## Timing
- Sweep length DEPTH cycles. After rst falls, edges 1..32 write addresses 0..31. busy is 0 and ready can assert in the cycle after edge 32.
- Read latency: 1 cycle from the acceptance edge to rd_data_valid.
- Write is visible to a read accepted in the following cycle (back-to-back RAW returns the new data).
- Throughput: one accepted request per cycle.
- Under continuous contention, grants alternate RD, WR, RD, …, and the first contention grants RD.
- rst asserted mid-operation:
  - Any pending rd_data_valid is dropped.
  - All outputs return to their reset values.
  - A full sweep reruns after release.

## Structure
- Package sram_ctrl_pkg: AW, DW, DEPTH constants; state enum {ST_SWEEP, ST_SERVE}; grant enum {GNT_RD, GNT_WR}.
- One sub-module, rr_arb2:
  - Inputs: 2 requests and last_grant.
  - Output: one-hot grant.
  - Purely combinational; the last_grant register stays in sram_ctrl.

## Test plan
- Reset release, no requests → busy high for exactly 32 cycles. Addresses 0..31 are written with data 0, then mem_ena = 0 and busy = 0.
- After sweep, write addr 5 = 72'h1_2345_6789_ABCD_EF01, then read addr 5 the next cycle → rd_data_valid one cycle after acceptance, rd_data = 72'h1_2345_6789_ABCD_EF01.
- rd_valid and wr_valid held high for 6 cycles (addrs 1..6) → grants alternate starting with RD: 3 reads and 3 writes, never both ready high.
- init_req pulsed mid-traffic, then again 10 cycles into the sweep → in-flight read response still delivered. Sweep restarts at address 0, and busy stays high 32 cycles after the second pulse.
- rst asserted for 2 cycles during a read acceptance → rd_data_valid stays 0, mem_ena = 0 while reset is held, and a full sweep follows release.
- Read of addr 31 after the sweep, with no prior writes → rd_data = 0.
